// File: rtl/ula_bus_controller_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
//
// Shared definitions for the ULA result-bus sequencing logic:
//   - op code encoding used on req_op (bit i of unit_en serves op i)
//   - controller state encoding
//   - default number of functional units hanging on the shared bus
//   - is_arith(): tells whether an op produces a meaningful carry/borrow
// ---------------------------------------------------------------------------
package ula_pkg;

   localparam int OP_W          = 3;
   localparam int NUM_UNITS_DEF = 6;

   localparam logic [OP_W-1:0] OP_AND = 3'd0;
   localparam logic [OP_W-1:0] OP_OR  = 3'd1;
   localparam logic [OP_W-1:0] OP_XOR = 3'd2;
   localparam logic [OP_W-1:0] OP_NOT = 3'd3;
   localparam logic [OP_W-1:0] OP_ADD = 3'd4;
   localparam logic [OP_W-1:0] OP_SUB = 3'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRIVE = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Only the adder/subtractor drives a real carry/borrow line.
   function automatic logic is_arith(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/ula_bus_controller_if.sv
// ---------------------------------------------------------------------------
// ula_bus_controller_if
//
// Bundles the request handshake, operand/enable outputs, shared result bus
// and response handshake of the ULA bus controller.
//   slave  : the controller side (accepts requests, drives enables/responses)
//   master : the environment side (issues requests, drives the result bus)
//
// Signals:
//   req_valid/req_ready/req_op/req_a/req_b  request handshake
//   opnd_a/opnd_b                           registered operands to all units
//   unit_en                                 one-hot tri-state enables
//   bus_in/carry_in                         shared result bus and carry line
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_carry/rsp_err                       response handshake
// ---------------------------------------------------------------------------
interface ula_bus_controller_if
   import ula_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int NUM_UNITS = NUM_UNITS_DEF
) ();

   logic                 req_valid;
   logic                 req_ready;
   logic [OP_W-1:0]      req_op;
   logic [WIDTH-1:0]     req_a;
   logic [WIDTH-1:0]     req_b;

   logic [WIDTH-1:0]     opnd_a;
   logic [WIDTH-1:0]     opnd_b;
   logic [NUM_UNITS-1:0] unit_en;
   logic [WIDTH-1:0]     bus_in;
   logic                 carry_in;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [WIDTH-1:0]     rsp_data;
   logic                 rsp_carry;
   logic                 rsp_err;

   modport slave (
      input  req_valid, req_op, req_a, req_b, bus_in, carry_in, rsp_ready,
      output req_ready, opnd_a, opnd_b, unit_en,
             rsp_valid, rsp_data, rsp_carry, rsp_err
   );

   modport master (
      output req_valid, req_op, req_a, req_b, bus_in, carry_in, rsp_ready,
      input  req_ready, opnd_a, opnd_b, unit_en,
             rsp_valid, rsp_data, rsp_carry, rsp_err
   );

endinterface

// File: rtl/ula_bus_controller_op_decode.sv
// ---------------------------------------------------------------------------
// ula_op_decode
//
// Purely combinational op code decoder for any master of the ULA result bus.
//   op     : requested operation code
//   onehot : enable vector, bit i set when op == i and i < NUM_UNITS
//   legal  : op addresses an existing unit
// An op with no matching unit yields an all-zero vector, so an illegal code
// can never turn a driver on.
// ---------------------------------------------------------------------------
module ula_op_decode
   import ula_pkg::*;
#(
   parameter int NUM_UNITS = NUM_UNITS_DEF
) (
   input  logic [OP_W-1:0]      op,
   output logic [NUM_UNITS-1:0] onehot,
   output logic                 legal
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         onehot[i] = (op == OP_W'(i));
      end
      legal = |onehot;
   end

endmodule

// File: rtl/ula_bus_controller.sv
// ---------------------------------------------------------------------------
// ula_bus_controller
//
// Sequences the ULA's shared tri-state result bus. One request at a time is
// accepted, its operands are registered onto opnd_a/opnd_b, and after one
// quiet cycle exactly one unit enable is held for SETTLE_CYCLES cycles. The
// bus value (and carry for ADD/SUB) is captured on the edge ending the drive
// window and returned over the response handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every output immediately so
//          no unit keeps driving the bus while reset is held
//   bus    ula_bus_controller_if.slave (request, operands, enables,
//          result bus, response)
//
// Parameters:
//   WIDTH          operand/bus width
//   NUM_UNITS      units on the bus; legal op codes are 0..NUM_UNITS-1
//   SETTLE_CYCLES  cycles the selected enable is held before capture (>=1)
// ---------------------------------------------------------------------------
module ula_bus_controller
   import ula_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int NUM_UNITS     = NUM_UNITS_DEF,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ula_bus_controller_if.slave  bus
);

   // A 1-bit counter suffices when the window is a single cycle.
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t               state;
   logic [OP_W-1:0]      op_q;
   logic [NUM_UNITS-1:0] sel_q;
   logic [CNT_W-1:0]     settle_cnt;

   logic                 ready_q;
   logic [WIDTH-1:0]     opnd_a_q;
   logic [WIDTH-1:0]     opnd_b_q;
   logic [NUM_UNITS-1:0] unit_en_q;
   logic                 rsp_valid_q;
   logic [WIDTH-1:0]     rsp_data_q;
   logic                 rsp_carry_q;
   logic                 rsp_err_q;

   logic [NUM_UNITS-1:0] dec_onehot;
   logic                 dec_legal;

   // Decode at acceptance time; the enable pattern is latched so the drive
   // window does not depend on req_op after the handshake.
   ula_op_decode #(
      .NUM_UNITS (NUM_UNITS)
   ) u_op_decode (
      .op     (bus.req_op),
      .onehot (dec_onehot),
      .legal  (dec_legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_q        <= '0;
         sel_q       <= '0;
         settle_cnt  <= '0;
         ready_q     <= 1'b0;
         opnd_a_q    <= '0;
         opnd_b_q    <= '0;
         unit_en_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid && ready_q) begin
                  op_q     <= bus.req_op;
                  opnd_a_q <= bus.req_a;
                  opnd_b_q <= bus.req_b;
                  sel_q    <= dec_onehot;
                  ready_q  <= 1'b0;
                  if (dec_legal) begin
                     state <= SETUP;
                  end else begin
                     // No unit exists for this code: answer with an error
                     // without ever touching the bus.
                     state       <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_carry_q <= 1'b0;
                  end
               end else begin
                  // Also covers the first cycle after reset release.
                  ready_q <= 1'b1;
               end
            end

            SETUP: begin
               // Operands have had one full cycle to reach every unit.
               unit_en_q  <= sel_q;
               settle_cnt <= CNT_LOAD;
               state      <= DRIVE;
            end

            DRIVE: begin
               if (settle_cnt == '0) begin
                  unit_en_q   <= '0;
                  rsp_data_q  <= bus.bus_in;
                  rsp_carry_q <= is_arith(op_q) & bus.carry_in;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end

            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               unit_en_q <= '0;
            end
         endcase
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.opnd_a    = opnd_a_q;
   assign bus.opnd_b    = opnd_b_q;
   assign bus.unit_en   = unit_en_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_carry = rsp_carry_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ula_bus_controller.sv
// ---------------------------------------------------------------------------
// tb_ula_bus_controller
//
// Two controllers share clock and reset: one with a single-cycle settle
// window and one with a three-cycle window. Each drives its own bus model
// that answers with the function of the enabled unit, a marker value when no
// single unit is enabled, and a carry line held high for non-arithmetic
// units so that a leaked carry is visible.
// ---------------------------------------------------------------------------
module tb_ula_bus_controller;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rr0   = 1'b1;
   logic rr1   = 1'b1;

   int checks    = 0;
   int failures  = 0;
   int to_events = 0;
   int to_seen   = 0;

   // Hand-computed result attached to the request being presented.
   logic [7:0] lit_d [2];
   logic       lit_c [2];
   logic       lit_e [2];

   // Transaction-level model state per controller.
   bit         busy    [2];
   bit         pend    [2];
   int         age     [2];
   logic [2:0] t_op    [2];
   logic [7:0] t_a     [2];
   logic [7:0] t_b     [2];
   logic [7:0] t_ld    [2];
   logic       t_lc    [2];
   logic       t_le    [2];
   logic [7:0] last_d  [2];
   logic       last_c  [2];
   logic       last_e  [2];
   logic [7:0] ex_oa   [2];
   logic [7:0] ex_ob   [2];

   ula_bus_controller_if #(.WIDTH(8), .NUM_UNITS(6)) bif1 ();
   ula_bus_controller_if #(.WIDTH(8), .NUM_UNITS(6)) bif3 ();

   ula_bus_controller #(.WIDTH(8), .NUM_UNITS(6), .SETTLE_CYCLES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif1)
   );

   ula_bus_controller #(.WIDTH(8), .NUM_UNITS(6), .SETTLE_CYCLES(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif3)
   );

   always #5 clk = ~clk;

   // ---------------- unit semantics and bus model ----------------
   function automatic logic [7:0] unit_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~a;
         3'd4:    return a + b;
         3'd5:    return a - b;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic unit_carry(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      if (op == 3'd4) return (int'(a) + int'(b)) > 255;
      if (op == 3'd5) return a < b;
      return 1'b0;
   endfunction

   function automatic logic [7:0] bus_val(input logic [5:0] en, input logic [7:0] a, input logic [7:0] b);
      if ($countones(en) != 1) return 8'hA5;
      for (int i = 0; i < 6; i++) begin
         if (en[i]) return unit_result(3'(i), a, b);
      end
      return 8'hA5;
   endfunction

   function automatic logic bus_carry(input logic [5:0] en, input logic [7:0] a, input logic [7:0] b);
      if (en == 6'b010000) return unit_carry(3'd4, a, b);
      if (en == 6'b100000) return unit_carry(3'd5, a, b);
      return 1'b1;
   endfunction

   assign bif1.bus_in    = bus_val(bif1.unit_en, bif1.opnd_a, bif1.opnd_b);
   assign bif1.carry_in  = bus_carry(bif1.unit_en, bif1.opnd_a, bif1.opnd_b);
   assign bif1.rsp_ready = rr0;
   assign bif3.bus_in    = bus_val(bif3.unit_en, bif3.opnd_a, bif3.opnd_b);
   assign bif3.carry_in  = bus_carry(bif3.unit_en, bif3.opnd_a, bif3.opnd_b);
   assign bif3.rsp_ready = rr1;

   // ---------------- comparison ----------------
   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s settle%0d actual=0x%0h required=0x%0h at %0t", nm, (k == 0) ? 1 : 3, act, exp, $time);
      end
   endtask

   task automatic check_inst(input int k, input logic rdy, input logic [5:0] en,
                             input logic [7:0] oa, input logic [7:0] ob,
                             input logic rv, input logic [7:0] rd, input logic rc, input logic re,
                             input logic qv, input logic rr,
                             input logic [2:0] qop, input logic [7:0] qa, input logic [7:0] qb);
      int         s;
      int         resp_age;
      bit         legal;
      bit         exp_rv;
      logic [5:0] exp_en;
      s = (k == 0) ? 1 : 3;
      if (!rst_n) begin
         chk("rst_req_ready", k, rdy, 0);
         chk("rst_unit_en",   k, en, 0);
         chk("rst_opnd_a",    k, oa, 0);
         chk("rst_opnd_b",    k, ob, 0);
         chk("rst_rsp_valid", k, rv, 0);
         chk("rst_rsp_data",  k, rd, 0);
         chk("rst_rsp_carry", k, rc, 0);
         chk("rst_rsp_err",   k, re, 0);
         busy[k]   = 0;
         pend[k]   = 1;
         last_d[k] = 8'h00;
         last_c[k] = 1'b0;
         last_e[k] = 1'b0;
         ex_oa[k]  = 8'h00;
         ex_ob[k]  = 8'h00;
      end else begin
         legal    = int'(t_op[k]) < 6;
         resp_age = legal ? s + 2 : 1;
         exp_en   = (busy[k] && legal && age[k] >= 2 && age[k] <= s + 1) ? (6'b000001 << t_op[k]) : 6'b000000;
         exp_rv   = busy[k] && (age[k] >= resp_age);
         if (exp_rv) begin
            if (legal) begin
               last_d[k] = unit_result(t_op[k], t_a[k], t_b[k]);
               last_c[k] = (t_op[k] == 3'd4 || t_op[k] == 3'd5) ? unit_carry(t_op[k], t_a[k], t_b[k]) : 1'b0;
               last_e[k] = 1'b0;
            end else begin
               last_d[k] = 8'h00;
               last_c[k] = 1'b0;
               last_e[k] = 1'b1;
            end
         end
         chk("req_ready", k, rdy, !busy[k] && !pend[k]);
         chk("unit_en",   k, en, exp_en);
         chk("one_hot",   k, $countones(en) <= 1, 1);
         chk("opnd_a",    k, oa, ex_oa[k]);
         chk("opnd_b",    k, ob, ex_ob[k]);
         chk("rsp_valid", k, rv, exp_rv);
         chk("rsp_data",  k, rd, last_d[k]);
         chk("rsp_carry", k, rc, last_c[k]);
         chk("rsp_err",   k, re, last_e[k]);
         if (exp_rv && rr) begin
            chk("lit_data",  k, rd, t_ld[k]);
            chk("lit_carry", k, rc, t_lc[k]);
            chk("lit_err",   k, re, t_le[k]);
         end
         // Predict the effect of the coming rising edge.
         if (busy[k]) begin
            if (exp_rv && rr) busy[k] = 0;
            else              age[k]++;
         end else if (qv && !pend[k]) begin
            busy[k]  = 1;
            age[k]   = 1;
            t_op[k]  = qop;
            t_a[k]   = qa;
            t_b[k]   = qb;
            ex_oa[k] = qa;
            ex_ob[k] = qb;
            t_ld[k]  = lit_d[k];
            t_lc[k]  = lit_c[k];
            t_le[k]  = lit_e[k];
         end
         pend[k] = 0;
      end
   endtask

   always @(negedge clk) begin
      check_inst(0, bif1.req_ready, bif1.unit_en, bif1.opnd_a, bif1.opnd_b,
                 bif1.rsp_valid, bif1.rsp_data, bif1.rsp_carry, bif1.rsp_err,
                 bif1.req_valid, bif1.rsp_ready, bif1.req_op, bif1.req_a, bif1.req_b);
      check_inst(1, bif3.req_ready, bif3.unit_en, bif3.opnd_a, bif3.opnd_b,
                 bif3.rsp_valid, bif3.rsp_data, bif3.rsp_carry, bif3.rsp_err,
                 bif3.req_valid, bif3.rsp_ready, bif3.req_op, bif3.req_a, bif3.req_b);
      if (to_events != to_seen) begin
         chk("accept_timeout", 0, to_events, to_seen);
         to_seen = to_events;
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic rdy_of(input int k);
      return (k == 0) ? bif1.req_ready : bif3.req_ready;
   endfunction

   task automatic set_req(input int k, input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      if (k == 0) begin
         bif1.req_valid = v; bif1.req_op = op; bif1.req_a = a; bif1.req_b = b;
      end else begin
         bif3.req_valid = v; bif3.req_op = op; bif3.req_a = a; bif3.req_b = b;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Waits until the presented request is taken, then withdraws it.
   task automatic wait_accept(input int k);
      bit ok;
      ok = 0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (rdy_of(k)) ok = 1;
      end
      @(posedge clk);
      #2;
      set_req(k, 1'b0, 3'd0, 8'h00, 8'h00);
      if (!ok) to_events++;
   endtask

   task automatic present(input int k, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ld, input logic lc, input logic le);
      lit_d[k] = ld;
      lit_c[k] = lc;
      lit_e[k] = le;
      set_req(k, 1'b1, op, a, b);
   endtask

   task automatic send(input int k, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ld, input logic lc, input logic le);
      present(k, op, a, b, ld, lc, le);
      wait_accept(k);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
      set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(1);

      // Single-cycle settle window.
      send(0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);   // AND
      send(0, 3'd4, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);   // ADD with carry out
      send(0, 3'd7, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1);   // illegal
      send(0, 3'd6, 8'h55, 8'hAA, 8'h00, 1'b0, 1'b1);   // illegal, first code past the units
      idle(4);

      // Response backpressure with a request waiting behind it.
      rr0 = 1'b0;
      send(0, 3'd1, 8'h0F, 8'hA0, 8'hAF, 1'b0, 1'b0);   // OR
      present(0, 3'd3, 8'h3C, 8'h00, 8'hC3, 1'b0, 1'b0); // NOT, held while busy
      idle(8);
      rr0 = 1'b1;
      wait_accept(0);
      idle(4);

      // Three-cycle settle window, back to back.
      send(1, 3'd2, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0);   // XOR
      send(1, 3'd5, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);   // SUB with borrow
      send(1, 3'd5, 8'h20, 8'h10, 8'h10, 1'b0, 1'b0);   // SUB without borrow
      idle(8);

      // Reset in the middle of a drive window.
      send(1, 3'd4, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      idle(2);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(2);

      send(1, 3'd4, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0);   // ADD after reset
      send(0, 3'd5, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0);   // SUB equal operands
      send(0, 3'd3, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0);   // NOT
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
